// File: rtl/arm_banked_reg_file.sv
// ARM register file with mode-banked R8-R14, ALU and load write ports, PC auto-increment,
// write-to-read forwarding and a per-register pending-load scoreboard.
module arm_banked_reg_file #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4:0]        MODE,
  input  logic [3:0]        RD_A_SEL,
  input  logic [3:0]        RD_B_SEL,
  input  logic [3:0]        RD_C_SEL,
  output logic [DATA_W-1:0] RD_A_DATA,
  output logic [DATA_W-1:0] RD_B_DATA,
  output logic [DATA_W-1:0] RD_C_DATA,
  output logic              RD_A_BUSY,
  output logic              RD_B_BUSY,
  output logic              RD_C_BUSY,
  input  logic              WR0_EN,
  input  logic [3:0]        WR0_SEL,
  input  logic [DATA_W-1:0] WR0_DATA,
  input  logic              WR1_EN,
  input  logic [3:0]        WR1_SEL,
  input  logic [DATA_W-1:0] WR1_DATA,
  input  logic              LOCK_EN,
  input  logic [3:0]        LOCK_SEL,
  input  logic              PC_WR_EN,
  input  logic [DATA_W-1:0] PC_WR_DATA,
  input  logic              PC_INC_EN,
  output logic [DATA_W-1:0] PC_DATA,
  output logic              ANY_BUSY
);

  typedef enum logic [2:0] {
    BANK_USR = 3'd0,
    BANK_FIQ = 3'd1,
    BANK_IRQ = 3'd2,
    BANK_SVC = 3'd3,
    BANK_ABT = 3'd4,
    BANK_UND = 3'd5
  } bank_t;

  // Physical layout: 0-7 shared, 8-12 USR R8-R12, 13-17 FIQ R8-R12,
  // 18-29 R13/R14 pairs per bank (USR first), 30 is the PC (held separately).
  localparam int                NUM_PHYS  = 30;
  localparam logic [4:0]        PHYS_PC   = 5'd30;
  localparam logic [DATA_W-1:0] PC_STEP_W = DATA_W'(PC_STEP);

  bank_t               bank;
  logic [4:0]          wr0_phys;
  logic [4:0]          wr1_phys;
  logic [4:0]          lock_phys;
  logic [DATA_W-1:0]   regs [NUM_PHYS];
  logic [DATA_W-1:0]   pc_q;
  logic [NUM_PHYS-1:0] lock_q;
  logic [3:0]          rd_sel  [3];
  logic [DATA_W-1:0]   rd_data [3];
  logic                rd_busy [3];

  // SYS and unrecognised mode codes fall back to the user bank.
  always_comb begin
    bank = BANK_USR;
    case (MODE)
      5'b10001: bank = BANK_FIQ;
      5'b10010: bank = BANK_IRQ;
      5'b10011: bank = BANK_SVC;
      5'b10111: bank = BANK_ABT;
      5'b11011: bank = BANK_UND;
      default:  bank = BANK_USR;
    endcase
  end

  function automatic logic [4:0] map_phys(input logic [3:0] sel, input bank_t bk);
    logic [4:0] idx;
    idx = {1'b0, sel};
    if (sel == 4'd15) begin
      idx = PHYS_PC;
    end else if (sel >= 4'd13) begin
      idx = 5'd18 + {1'b0, bk, 1'b0} + 5'(sel - 4'd13);
    end else if (sel >= 4'd8 && bk == BANK_FIQ) begin
      idx = 5'd13 + 5'(sel - 4'd8);
    end
    return idx;
  endfunction

  assign wr0_phys  = map_phys(WR0_SEL, bank);
  assign wr1_phys  = map_phys(WR1_SEL, bank);
  assign lock_phys = map_phys(LOCK_SEL, bank);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        if (WR1_EN && wr1_phys == 5'(i)) begin
          regs[i] <= WR1_DATA;
        end else if (WR0_EN && wr0_phys == 5'(i)) begin
          regs[i] <= WR0_DATA;
        end
      end
    end
  end

  // Load return beats ALU result, which beats a branch, which beats sequential fetch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= RESET_PC;
    end else if (WR1_EN && wr1_phys == PHYS_PC) begin
      pc_q <= WR1_DATA;
    end else if (WR0_EN && wr0_phys == PHYS_PC) begin
      pc_q <= WR0_DATA;
    end else if (PC_WR_EN) begin
      pc_q <= PC_WR_DATA;
    end else if (PC_INC_EN) begin
      pc_q <= pc_q + PC_STEP_W;
    end
  end

  // A new lock wins over a returning load so a re-issued load stays outstanding.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        if (LOCK_EN && lock_phys == 5'(i)) begin
          lock_q[i] <= 1'b1;
        end else if (WR1_EN && wr1_phys == 5'(i)) begin
          lock_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rd_sel[0] = RD_A_SEL;
  assign rd_sel[1] = RD_B_SEL;
  assign rd_sel[2] = RD_C_SEL;

  for (genvar p = 0; p < 3; p++) begin : g_port
    logic [4:0]        phys;
    logic [DATA_W-1:0] stored;
    logic              wr1_hit;
    logic              wr0_hit;

    assign phys    = map_phys(rd_sel[p], bank);
    assign stored  = (phys == PHYS_PC) ? pc_q : regs[phys];
    assign wr1_hit = BYPASS && WR1_EN && (wr1_phys == phys);
    assign wr0_hit = BYPASS && WR0_EN && (wr0_phys == phys);

    assign rd_data[p] = wr1_hit ? WR1_DATA : (wr0_hit ? WR0_DATA : stored);
    assign rd_busy[p] = (phys != PHYS_PC) && lock_q[phys] && !wr1_hit;
  end

  assign RD_A_DATA = rd_data[0];
  assign RD_B_DATA = rd_data[1];
  assign RD_C_DATA = rd_data[2];
  assign RD_A_BUSY = rd_busy[0];
  assign RD_B_BUSY = rd_busy[1];
  assign RD_C_BUSY = rd_busy[2];
  assign PC_DATA   = pc_q;
  assign ANY_BUSY  = |lock_q;

endmodule

// File: tb/tb_arm_banked_reg_file.sv
// Bench for arm_banked_reg_file: a forwarding and a non-forwarding copy share stimulus and are
// compared each cycle against a model that keeps a full 16-register view per bank.
module tb_arm_banked_reg_file;
  localparam int         W   = 32;
  localparam logic [W-1:0] RPC = 32'h100;

  typedef struct packed {
    logic [4:0]   mode;
    logic [3:0]   selA;
    logic [3:0]   selB;
    logic [3:0]   selC;
    logic         wr0En;
    logic [3:0]   wr0Sel;
    logic [W-1:0] wr0Data;
    logic         wr1En;
    logic [3:0]   wr1Sel;
    logic [W-1:0] wr1Data;
    logic         lockEn;
    logic [3:0]   lockSel;
    logic         pcWrEn;
    logic [W-1:0] pcWrData;
    logic         pcIncEn;
  } stim_t;

  logic CLK = 1'b0;
  logic RST;
  logic [4:0] MODE;
  logic [3:0] RD_A_SEL, RD_B_SEL, RD_C_SEL;
  logic WR0_EN, WR1_EN, LOCK_EN, PC_WR_EN, PC_INC_EN;
  logic [3:0] WR0_SEL, WR1_SEL, LOCK_SEL;
  logic [W-1:0] WR0_DATA, WR1_DATA, PC_WR_DATA;

  // index 1 = forwarding copy, index 0 = stored-contents-only copy
  logic [W-1:0] aData [2];
  logic [W-1:0] bData [2];
  logic [W-1:0] cData [2];
  logic [W-1:0] pcData [2];
  logic aBusy [2];
  logic bBusy [2];
  logic cBusy [2];
  logic anyBusy [2];

  logic [W-1:0] mReg [6][16];
  bit           mLock [6][16];
  logic [W-1:0] mPc;
  logic [4:0]   modeList [9];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  arm_banked_reg_file #(.DATA_W(W), .RESET_PC(RPC), .PC_STEP(4), .BYPASS(1'b1)) dutByp (
    .CLK(CLK), .RST(RST), .MODE(MODE),
    .RD_A_SEL(RD_A_SEL), .RD_B_SEL(RD_B_SEL), .RD_C_SEL(RD_C_SEL),
    .RD_A_DATA(aData[1]), .RD_B_DATA(bData[1]), .RD_C_DATA(cData[1]),
    .RD_A_BUSY(aBusy[1]), .RD_B_BUSY(bBusy[1]), .RD_C_BUSY(cBusy[1]),
    .WR0_EN(WR0_EN), .WR0_SEL(WR0_SEL), .WR0_DATA(WR0_DATA),
    .WR1_EN(WR1_EN), .WR1_SEL(WR1_SEL), .WR1_DATA(WR1_DATA),
    .LOCK_EN(LOCK_EN), .LOCK_SEL(LOCK_SEL),
    .PC_WR_EN(PC_WR_EN), .PC_WR_DATA(PC_WR_DATA), .PC_INC_EN(PC_INC_EN),
    .PC_DATA(pcData[1]), .ANY_BUSY(anyBusy[1])
  );

  arm_banked_reg_file #(.DATA_W(W), .RESET_PC(RPC), .PC_STEP(4), .BYPASS(1'b0)) dutRaw (
    .CLK(CLK), .RST(RST), .MODE(MODE),
    .RD_A_SEL(RD_A_SEL), .RD_B_SEL(RD_B_SEL), .RD_C_SEL(RD_C_SEL),
    .RD_A_DATA(aData[0]), .RD_B_DATA(bData[0]), .RD_C_DATA(cData[0]),
    .RD_A_BUSY(aBusy[0]), .RD_B_BUSY(bBusy[0]), .RD_C_BUSY(cBusy[0]),
    .WR0_EN(WR0_EN), .WR0_SEL(WR0_SEL), .WR0_DATA(WR0_DATA),
    .WR1_EN(WR1_EN), .WR1_SEL(WR1_SEL), .WR1_DATA(WR1_DATA),
    .LOCK_EN(LOCK_EN), .LOCK_SEL(LOCK_SEL),
    .PC_WR_EN(PC_WR_EN), .PC_WR_DATA(PC_WR_DATA), .PC_INC_EN(PC_INC_EN),
    .PC_DATA(pcData[0]), .ANY_BUSY(anyBusy[0])
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 USR/SYS/other, 1 FIQ, 2 IRQ, 3 SVC, 4 ABT, 5 UND
  function automatic int bankOf(input logic [4:0] m);
    case (m)
      5'b10001: return 1;
      5'b10010: return 2;
      5'b10011: return 3;
      5'b10111: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  // Does a write of logical r made in bank wb show up in bank b's view of r?
  function automatic bit shares(input int wb, input int r, input int b);
    if (r < 8) return 1'b1;
    if (r <= 12) return (wb == 1) == (b == 1);
    return wb == b;
  endfunction

  task automatic resetModel();
    for (int b = 0; b < 6; b++) begin
      for (int r = 0; r < 16; r++) begin
        mReg[b][r] = '0;
        mLock[b][r] = 1'b0;
      end
    end
    mPc = RPC;
  endtask

  task automatic modelWrite(input int wb, input int r, input logic [W-1:0] d);
    if (r == 15) begin
      mPc = d;
    end else begin
      for (int b = 0; b < 6; b++) begin
        if (shares(wb, r, b)) mReg[b][r] = d;
      end
    end
  endtask

  // Lower-priority sources are applied first so the highest-priority write lands last.
  task automatic modelClock();
    int cb;
    cb = bankOf(MODE);
    if (PC_INC_EN) mPc = mPc + 32'd4;
    if (PC_WR_EN) mPc = PC_WR_DATA;
    if (WR0_EN) modelWrite(cb, int'(WR0_SEL), WR0_DATA);
    if (WR1_EN) modelWrite(cb, int'(WR1_SEL), WR1_DATA);
    if (WR1_EN && WR1_SEL != 4'd15) begin
      for (int b = 0; b < 6; b++) if (shares(cb, int'(WR1_SEL), b)) mLock[b][WR1_SEL] = 1'b0;
    end
    if (LOCK_EN && LOCK_SEL != 4'd15) begin
      for (int b = 0; b < 6; b++) if (shares(cb, int'(LOCK_SEL), b)) mLock[b][LOCK_SEL] = 1'b1;
    end
  endtask

  function automatic logic [W-1:0] modelRead(input logic [3:0] sel, input bit byp);
    if (byp && WR1_EN && WR1_SEL == sel) return WR1_DATA;
    if (byp && WR0_EN && WR0_SEL == sel) return WR0_DATA;
    if (sel == 4'd15) return mPc;
    return mReg[bankOf(MODE)][sel];
  endfunction

  function automatic logic modelBusy(input logic [3:0] sel, input bit byp);
    if (sel == 4'd15) return 1'b0;
    if (byp && WR1_EN && WR1_SEL == sel) return 1'b0;
    return mLock[bankOf(MODE)][sel];
  endfunction

  function automatic logic modelAnyBusy();
    logic any = 1'b0;
    for (int b = 0; b < 6; b++) for (int r = 0; r < 16; r++) any |= mLock[b][r];
    return any;
  endfunction

  task automatic checkAll();
    string n;
    for (int d = 0; d < 2; d++) begin
      n = (d == 1) ? "byp" : "raw";
      checkOutput({n, ".rdA"}, aData[d], modelRead(RD_A_SEL, d == 1));
      checkOutput({n, ".rdB"}, bData[d], modelRead(RD_B_SEL, d == 1));
      checkOutput({n, ".rdC"}, cData[d], modelRead(RD_C_SEL, d == 1));
      checkOutput({n, ".busyA"}, W'(aBusy[d]), W'(modelBusy(RD_A_SEL, d == 1)));
      checkOutput({n, ".busyB"}, W'(bBusy[d]), W'(modelBusy(RD_B_SEL, d == 1)));
      checkOutput({n, ".busyC"}, W'(cBusy[d]), W'(modelBusy(RD_C_SEL, d == 1)));
      checkOutput({n, ".pc"}, pcData[d], mPc);
      checkOutput({n, ".anyBusy"}, W'(anyBusy[d]), W'(modelAnyBusy()));
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s = '0;
    s.mode = 5'b10000;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    MODE = s.mode; RD_A_SEL = s.selA; RD_B_SEL = s.selB; RD_C_SEL = s.selC;
    WR0_EN = s.wr0En; WR0_SEL = s.wr0Sel; WR0_DATA = s.wr0Data;
    WR1_EN = s.wr1En; WR1_SEL = s.wr1Sel; WR1_DATA = s.wr1Data;
    LOCK_EN = s.lockEn; LOCK_SEL = s.lockSel;
    PC_WR_EN = s.pcWrEn; PC_WR_DATA = s.pcWrData; PC_INC_EN = s.pcIncEn;
  endtask

  // Called 1 time unit after a rising edge; checks combinational outputs mid-cycle.
  task automatic applyStimulus(input stim_t s);
    drive(s);
    #2;
    checkAll();
  endtask

  task automatic clockCycle();
    modelClock();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input stim_t s);
    applyStimulus(s);
    clockCycle();
  endtask

  // Asserts reset in the middle of a cycle and checks the outputs respond before any edge.
  task automatic midReset();
    applyStimulus(idleStim());
    #1 RST = 1'b1;
    #1;
    resetModel();
    checkAll();
    checkOutput("rst.pc", pcData[1], 32'h100);
    checkOutput("rst.anyBusy", W'(anyBusy[1]), '0);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  function automatic logic [3:0] pickSel();
    if ($urandom_range(0, 1) == 1) return 4'($urandom_range(6, 15));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    stim_t s;
    modeList[0] = 5'b10000; modeList[1] = 5'b10001; modeList[2] = 5'b10010;
    modeList[3] = 5'b10011; modeList[4] = 5'b10111; modeList[5] = 5'b11011;
    modeList[6] = 5'b11111; modeList[7] = 5'b00000; modeList[8] = 5'b01010;

    RST = 1'b1;
    drive(idleStim());
    resetModel();
    #3;
    checkAll();
    checkOutput("init.pc", pcData[1], 32'h100);
    @(posedge CLK);
    #1 RST = 1'b0;

    // R3 write then read back
    s = idleStim(); s.wr0En = 1; s.wr0Sel = 4'd3; s.wr0Data = 32'hDEADBEEF; step(s);
    s = idleStim(); s.selA = 4'd3; applyStimulus(s);
    checkOutput("r3.read", aData[1], 32'hDEADBEEF);
    checkOutput("r3.readRaw", aData[0], 32'hDEADBEEF);
    clockCycle();

    // Banking
    s = idleStim(); s.wr0En = 1; s.wr0Sel = 4'd13; s.wr0Data = 32'h1111; step(s);
    s = idleStim(); s.mode = 5'b10010; s.wr0En = 1; s.wr0Sel = 4'd13; s.wr0Data = 32'h2222; step(s);
    s = idleStim(); s.mode = 5'b10001; s.wr0En = 1; s.wr0Sel = 4'd8; s.wr0Data = 32'h3333; step(s);
    s = idleStim(); s.selA = 4'd13; s.selB = 4'd8; applyStimulus(s);
    checkOutput("usr.r13", aData[1], 32'h1111);
    checkOutput("usr.r8", bData[1], 32'h0);
    clockCycle();
    s.mode = 5'b10010; applyStimulus(s);
    checkOutput("irq.r13", aData[1], 32'h2222);
    clockCycle();
    s.mode = 5'b10001; applyStimulus(s);
    checkOutput("fiq.r8", bData[1], 32'h3333);
    clockCycle();
    s.mode = 5'b11111; applyStimulus(s);
    checkOutput("sys.r13", aData[1], 32'h1111);
    clockCycle();
    s.mode = 5'b00000; applyStimulus(s);
    checkOutput("undef.r13", aData[1], 32'h1111);
    clockCycle();

    // Dual write to one register: load port wins, raw copy shows old value
    s = idleStim(); s.selB = 4'd5;
    s.wr0En = 1; s.wr0Sel = 4'd5; s.wr0Data = 32'hA;
    s.wr1En = 1; s.wr1Sel = 4'd5; s.wr1Data = 32'hB;
    applyStimulus(s);
    checkOutput("byp.wr1wins", bData[1], 32'hB);
    checkOutput("raw.old", bData[0], 32'h0);
    clockCycle();
    s = idleStim(); s.selB = 4'd5; applyStimulus(s);
    checkOutput("raw.stored", bData[0], 32'hB);
    clockCycle();

    // PC increment, priorities and wrap
    s = idleStim(); s.pcWrEn = 1; s.pcWrData = 32'h100; step(s);
    s = idleStim(); s.pcIncEn = 1; step(s); step(s); step(s);
    applyStimulus(idleStim());
    checkOutput("pc.inc3", pcData[1], 32'h10C);
    clockCycle();
    s = idleStim(); s.pcWrEn = 1; s.pcWrData = 32'h2000; s.pcIncEn = 1; step(s);
    applyStimulus(idleStim());
    checkOutput("pc.branch", pcData[1], 32'h2000);
    clockCycle();
    s = idleStim(); s.wr0En = 1; s.wr0Sel = 4'd15; s.wr0Data = 32'h40;
    s.pcWrEn = 1; s.pcWrData = 32'h999; step(s);
    applyStimulus(idleStim());
    checkOutput("pc.wr0", pcData[1], 32'h40);
    clockCycle();
    s = idleStim(); s.pcWrEn = 1; s.pcWrData = 32'hFFFFFFFC; step(s);
    s = idleStim(); s.pcIncEn = 1; step(s);
    applyStimulus(idleStim());
    checkOutput("pc.wrap", pcData[1], 32'h0);
    clockCycle();

    // Scoreboard on R7
    s = idleStim(); s.lockEn = 1; s.lockSel = 4'd7; step(s);
    s = idleStim(); s.selC = 4'd7; applyStimulus(s);
    checkOutput("lock.busy", W'(cBusy[1]), 32'h1);
    checkOutput("lock.any", W'(anyBusy[1]), 32'h1);
    clockCycle();
    s.wr1En = 1; s.wr1Sel = 4'd7; s.wr1Data = 32'h55; applyStimulus(s);
    checkOutput("ld.busyByp", W'(cBusy[1]), 32'h0);
    checkOutput("ld.dataByp", cData[1], 32'h55);
    checkOutput("ld.busyRaw", W'(cBusy[0]), 32'h1);
    clockCycle();
    s = idleStim(); s.selC = 4'd7; applyStimulus(s);
    checkOutput("ld.cleared", W'(cBusy[0]), 32'h0);
    clockCycle();
    s.lockEn = 1; s.lockSel = 4'd7; s.wr1En = 1; s.wr1Sel = 4'd7; s.wr1Data = 32'h66; step(s);
    s = idleStim(); s.selC = 4'd7; applyStimulus(s);
    checkOutput("relock.busy", W'(cBusy[1]), 32'h1);
    clockCycle();
    s.wr1En = 1; s.wr1Sel = 4'd7; s.wr1Data = 32'h77; step(s);

    // Reset with locks outstanding
    s = idleStim(); s.lockEn = 1; s.lockSel = 4'd2; step(s);
    s = idleStim(); s.mode = 5'b10010; s.lockEn = 1; s.lockSel = 4'd14; step(s);
    s = idleStim(); s.mode = 5'b10010; s.selA = 4'd14; applyStimulus(s);
    checkOutput("irq.r14busy", W'(aBusy[1]), 32'h1);
    clockCycle();
    midReset();
    s = idleStim(); s.wr1En = 1; s.wr1Sel = 4'd2; s.wr1Data = 32'h77; step(s);
    s = idleStim(); s.selA = 4'd2; applyStimulus(s);
    checkOutput("postrst.r2", aData[0], 32'h77);
    clockCycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      s = idleStim();
      s.mode = modeList[$urandom_range(0, 8)];
      s.selA = pickSel(); s.selB = pickSel(); s.selC = pickSel();
      s.wr0En = ($urandom_range(0, 2) != 0); s.wr0Sel = pickSel(); s.wr0Data = $urandom;
      s.wr1En = ($urandom_range(0, 2) == 0); s.wr1Sel = pickSel(); s.wr1Data = $urandom;
      s.lockEn = ($urandom_range(0, 2) == 0); s.lockSel = pickSel();
      s.pcWrEn = ($urandom_range(0, 7) == 0); s.pcWrData = $urandom;
      s.pcIncEn = ($urandom_range(0, 1) == 1);
      step(s);
      if (n == 250) midReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
